// File: rtl/multi_mem_arbiter_pkg.sv
// rtl/multi_mem_arbiter_pkg.sv - shared constants and state type for the N-port memory arbiter
package mem_arb_pkg;

    localparam int PORT_DATA  = 0;
    localparam int PORT_INSTR = 1;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/multi_mem_arbiter_if.sv
// rtl/multi_mem_arbiter_if.sv - requester-side and memory-side bus bundle for multi_mem_arbiter
interface multi_mem_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16
);
    localparam int BYTESEL_W = DATA_W / 8;
    localparam int IDX_W     = $clog2(NUM_PORTS);

    logic [NUM_PORTS*ADDR_W-1:0]    req_addr;
    logic [NUM_PORTS*DATA_W-1:0]    req_data_out;
    logic [NUM_PORTS-1:0]           req_access;
    logic [NUM_PORTS-1:0]           req_wr_en;
    logic [NUM_PORTS*BYTESEL_W-1:0] req_bytesel;
    logic [DATA_W-1:0]              req_data_in;
    logic [NUM_PORTS-1:0]           req_ack;

    logic [ADDR_W-1:0]              q_m_addr;
    logic [DATA_W-1:0]              q_m_data_in;
    logic [DATA_W-1:0]              q_m_data_out;
    logic                           q_m_access;
    logic                           q_m_ack;
    logic                           q_m_wr_en;
    logic [BYTESEL_W-1:0]           q_m_bytesel;

    logic [IDX_W-1:0]               grant_idx;

    // Arbiter view: serves the requesters, drives the memory bus.
    modport slave (
        input  req_addr, req_data_out, req_access, req_wr_en, req_bytesel,
        input  q_m_data_in, q_m_ack,
        output req_data_in, req_ack,
        output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
        output grant_idx
    );

    modport master (
        output req_addr, req_data_out, req_access, req_wr_en, req_bytesel,
        output q_m_data_in, q_m_ack,
        input  req_data_in, req_ack,
        input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
        input  grant_idx
    );

endinterface

// File: rtl/multi_mem_arbiter_rr_priority_picker.sv
// rtl/multi_mem_arbiter_rr_priority_picker.sv - find-first-set over N requests starting at a given index, wrapping
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        idx     = '0;
        valid   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (!valid && req[pos_idx]) begin
                valid = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/multi_mem_arbiter.sv
// rtl/multi_mem_arbiter.sv - N-port single-outstanding memory arbiter, fixed priority or
// round-robin when MEM_ARB_ROUND_ROBIN_EN is defined
module multi_mem_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    multi_mem_arbiter_if.slave  bus
);
    import mem_arb_pkg::*;

    localparam int BYTESEL_W = DATA_W / 8;
    localparam int IDX_W     = $clog2(NUM_PORTS);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     pick_start;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_valid;
    logic                 any_req;
    logic [IDX_W-1:0]     sel;
    logic [NUM_PORTS-1:0] ack_vec;
    logic                 access_o;
    logic                 wr_o;

    assign any_req = |bus.req_access;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_q;

    // Pointer moves past the port just served so it cannot win twice in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else if (state_q == GRANTED && bus.q_m_ack) begin
            rr_q <= (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
        end
    end

    assign pick_start = rr_q;
`else
    assign pick_start = '0;
`endif

    rr_priority_picker #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (bus.req_access),
        .start (pick_start),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q <= win_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)     state_d = GRANTED;
            GRANTED: if (bus.q_m_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the bus follows the live winner so a lone request starts with no added latency.
    always_comb begin
        sel      = IDX_W'(PORT_DATA);
        ack_vec  = '0;
        access_o = 1'b0;
        wr_o     = 1'b0;
        if (state_q == GRANTED) begin
            sel              = grant_q;
            access_o         = ~bus.q_m_ack;
            wr_o             = bus.req_wr_en[grant_q];
            ack_vec[grant_q] = bus.q_m_ack;
        end else begin
            if (win_valid) begin
                sel = win_idx;
            end
            access_o = any_req;
            wr_o     = any_req & bus.req_wr_en[sel];
        end
    end

    assign bus.q_m_addr     = bus.req_addr[int'(sel)*ADDR_W +: ADDR_W];
    assign bus.q_m_data_out = bus.req_data_out[int'(sel)*DATA_W +: DATA_W];
    assign bus.q_m_bytesel  = bus.req_bytesel[int'(sel)*BYTESEL_W +: BYTESEL_W];
    assign bus.q_m_access   = access_o;
    assign bus.q_m_wr_en    = wr_o;
    assign bus.req_ack      = ack_vec;
    assign bus.req_data_in  = bus.q_m_data_in;
    assign bus.grant_idx    = grant_q;

endmodule

// File: tb/tb_multi_mem_arbiter.sv
// tb/tb_multi_mem_arbiter.sv - self-checking bench for multi_mem_arbiter with a transaction-level reference model
module tb_multi_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BW = DW / 8;
    localparam int IW = $clog2(N);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    multi_mem_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    multi_mem_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic set_port(input int i, input logic acc, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic wr, input logic [BW-1:0] bs);
        bus.req_access[i]          = acc;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_data_out[i*DW +: DW] = d;
        bus.req_wr_en[i]           = wr;
        bus.req_bytesel[i*BW +: BW] = bs;
    endtask

    task automatic clear_all();
        bus.req_access   = '0;
        bus.req_addr     = '0;
        bus.req_data_out = '0;
        bus.req_wr_en    = '0;
        bus.req_bytesel  = '0;
        bus.q_m_ack      = 1'b0;
        bus.q_m_data_in  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_all();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Spec selection rule: scan from start, wrapping, first requester wins.
    function automatic int pick(input logic [N-1:0] v, input int start);
        int p;
        for (int k = 0; k < N; k++) begin
            p = (start + k) % N;
            if (v[p[IW-1:0]]) return p;
        end
        return 0;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        clear_all();
        reset = 1'b1;
        #1;
        tests++; if (bus.req_ack !== 4'b0000) begin $display("FAIL reset_ack: got %b expected 0000", bus.req_ack); fails++; end
        tests++; if (bus.q_m_access !== 1'b0) begin $display("FAIL reset_access: got %b expected 0", bus.q_m_access); fails++; end
        tests++; if (bus.q_m_wr_en !== 1'b0) begin $display("FAIL reset_wr_en: got %b expected 0", bus.q_m_wr_en); fails++; end
        tests++; if (bus.grant_idx !== 2'd0) begin $display("FAIL reset_grant: got %0d expected 0", bus.grant_idx); fails++; end
        set_port(2, 1'b1, 19'h00777, 16'h0, 1'b1, 2'b11);
        bus.q_m_ack = 1'b1;
        #1;
        tests++; if (bus.req_ack !== 4'b0000) begin $display("FAIL reset_req_ack: got %b expected 0000", bus.req_ack); fails++; end
        tests++; if (bus.q_m_access !== 1'b1) begin $display("FAIL reset_req_access: got %b expected 1", bus.q_m_access); fails++; end
        tests++; if (bus.q_m_wr_en !== 1'b1) begin $display("FAIL reset_req_wr_en: got %b expected 1", bus.q_m_wr_en); fails++; end
        tests++; if (bus.grant_idx !== 2'd0) begin $display("FAIL reset_req_grant: got %0d expected 0", bus.grant_idx); fails++; end
        @(negedge clk);
        clear_all();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int acks;
        logic [N-1:0] e_ack;
        acks = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_port(2, c < 4, 19'h00100, 16'h0, 1'b0, 2'b11);
            bus.q_m_ack     = (c == 3);
            bus.q_m_data_in = (c == 3) ? 16'h1234 : 16'h0000;
            #1;
            e_ack = (c == 3) ? 4'b0100 : 4'b0000;
            if (bus.req_ack != 4'b0000) acks++;
            tests++; if (bus.req_ack !== e_ack) begin $display("FAIL single_ack c%0d: got %b expected %b", c, bus.req_ack, e_ack); fails++; end
            tests++; if (bus.q_m_access !== (c < 3)) begin $display("FAIL single_access c%0d: got %b expected %b", c, bus.q_m_access, c < 3); fails++; end
            if (c < 4) begin
                tests++; if (bus.q_m_addr !== 19'h00100) begin $display("FAIL single_addr c%0d: got %h expected 00100", c, bus.q_m_addr); fails++; end
            end
            if (c >= 1) begin
                tests++; if (bus.grant_idx !== 2'd2) begin $display("FAIL single_grant c%0d: got %0d expected 2", c, bus.grant_idx); fails++; end
            end
            if (c == 3) begin
                tests++; if (bus.req_data_in !== 16'h1234) begin $display("FAIL single_rdata: got %h expected 1234", bus.req_data_in); fails++; end
            end
        end
        tests++; if (acks !== 1) begin $display("FAIL single_ack_count: got %0d expected 1", acks); fails++; end
    endtask

    task automatic test_two_port_priority();
        logic [N-1:0]  e_ack [5]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        logic          e_acc [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic          e_wr  [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [BW-1:0] e_bs  [4]  = '{2'b01, 2'b01, 2'b11, 2'b11};
        logic [AW-1:0] e_ad  [4]  = '{19'h0A0A0, 19'h0A0A0, 19'h1B1B1, 19'h1B1B1};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_port(PORT_DATA,  c < 2, 19'h0A0A0, 16'h1111, 1'b1, 2'b01);
            set_port(PORT_INSTR, c < 4, 19'h1B1B1, 16'h2222, 1'b0, 2'b11);
            bus.q_m_ack = (c == 1) || (c == 3);
            #1;
            tests++; if (bus.req_ack !== e_ack[c]) begin $display("FAIL prio_ack c%0d: got %b expected %b", c, bus.req_ack, e_ack[c]); fails++; end
            tests++; if (bus.q_m_access !== e_acc[c]) begin $display("FAIL prio_access c%0d: got %b expected %b", c, bus.q_m_access, e_acc[c]); fails++; end
            if (c < 4) begin
                tests++; if (bus.q_m_wr_en !== e_wr[c]) begin $display("FAIL prio_wr c%0d: got %b expected %b", c, bus.q_m_wr_en, e_wr[c]); fails++; end
                tests++; if (bus.q_m_bytesel !== e_bs[c]) begin $display("FAIL prio_bs c%0d: got %b expected %b", c, bus.q_m_bytesel, e_bs[c]); fails++; end
                tests++; if (bus.q_m_addr !== e_ad[c]) begin $display("FAIL prio_addr c%0d: got %h expected %h", c, bus.q_m_addr, e_ad[c]); fails++; end
            end
        end
    endtask

    task automatic test_hold_all();
        int order [5];
        int exp_order [5];
        int nacks;
        nacks = 0;
        for (int k = 0; k < 5; k++) exp_order[k] = RR ? (k % N) : 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) set_port(i, 1'b1, AW'(19'h01000 + i), DW'(i), 1'b0, 2'b11);
            bus.q_m_ack = 1'b1;
            #1;
            tests++; if (bus.q_m_access !== (c % 2 == 0)) begin $display("FAIL hold_access c%0d: got %b expected %b", c, bus.q_m_access, c % 2 == 0); fails++; end
            if (bus.req_ack != 4'b0000 && nacks < 5) begin
                tests++; if (bus.req_ack !== 4'(1 << exp_order[nacks])) begin $display("FAIL hold_ack_port k%0d: got %b expected port %0d", nacks, bus.req_ack, exp_order[nacks]); fails++; end
                order[nacks] = pick(bus.req_ack, 0);
                nacks++;
            end
        end
        tests++; if (nacks !== 5) begin $display("FAIL hold_ack_count: got %0d expected 5", nacks); fails++; end
        clear_all();
    endtask

    task automatic test_drop_access();
        logic [N-1:0] e_ack;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_port(1, c < 2, 19'h2AAAA, 16'hBEEF, 1'b1, 2'b10);
            bus.q_m_ack = (c == 3);
            #1;
            e_ack = (c == 3) ? 4'b0010 : 4'b0000;
            tests++; if (bus.req_ack !== e_ack) begin $display("FAIL drop_ack c%0d: got %b expected %b", c, bus.req_ack, e_ack); fails++; end
            tests++; if (bus.q_m_access !== (c < 3)) begin $display("FAIL drop_access c%0d: got %b expected %b", c, bus.q_m_access, c < 3); fails++; end
            if (c < 4) begin
                tests++; if (bus.q_m_data_out !== 16'hBEEF) begin $display("FAIL drop_wdata c%0d: got %h expected beef", c, bus.q_m_data_out); fails++; end
                tests++; if (bus.q_m_bytesel !== 2'b10) begin $display("FAIL drop_bs c%0d: got %b expected 10", c, bus.q_m_bytesel); fails++; end
                tests++; if (bus.q_m_wr_en !== 1'b1) begin $display("FAIL drop_wr c%0d: got %b expected 1", c, bus.q_m_wr_en); fails++; end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        set_port(3, 1'b1, 19'h00333, 16'h0, 1'b0, 2'b11);
        @(negedge clk);
        #1;
        tests++; if (bus.grant_idx !== 2'd3) begin $display("FAIL mid_grant_before: got %0d expected 3", bus.grant_idx); fails++; end
        @(negedge clk);
        set_port(1, 1'b1, 19'h00111, 16'h0, 1'b0, 2'b11);
        bus.q_m_ack = 1'b1;
        reset = 1'b1;
        #1;
        tests++; if (bus.req_ack !== 4'b0000) begin $display("FAIL mid_reset_ack: got %b expected 0000", bus.req_ack); fails++; end
        tests++; if (bus.grant_idx !== 2'd0) begin $display("FAIL mid_reset_grant: got %0d expected 0", bus.grant_idx); fails++; end
        tests++; if (bus.q_m_access !== 1'b1) begin $display("FAIL mid_reset_access: got %b expected 1", bus.q_m_access); fails++; end
        tests++; if (bus.q_m_addr !== 19'h00111) begin $display("FAIL mid_reset_addr: got %h expected 00111", bus.q_m_addr); fails++; end
        @(negedge clk);
        reset = 1'b0;
        bus.q_m_ack = 1'b0;
        #1;
        tests++; if (bus.req_ack !== 4'b0000) begin $display("FAIL mid_idle_ack: got %b expected 0000", bus.req_ack); fails++; end
        @(negedge clk);
        bus.q_m_ack = 1'b1;
        #1;
        tests++; if (bus.req_ack !== 4'b0010) begin $display("FAIL mid_rearb_ack: got %b expected 0010", bus.req_ack); fails++; end
        tests++; if (bus.grant_idx !== 2'd1) begin $display("FAIL mid_rearb_grant: got %0d expected 1", bus.grant_idx); fails++; end
        @(negedge clk);
        clear_all();
    endtask

    task automatic test_idle_ack();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_port(0, 1'b0, 19'h05555, 16'h0, 1'b1, 2'b11);
            bus.q_m_ack = 1'b1;
            #1;
            tests++; if (bus.req_ack !== 4'b0000) begin $display("FAIL idle_ack c%0d: got %b expected 0000", c, bus.req_ack); fails++; end
            tests++; if (bus.q_m_access !== 1'b0) begin $display("FAIL idle_access c%0d: got %b expected 0", c, bus.q_m_access); fails++; end
            tests++; if (bus.q_m_wr_en !== 1'b0) begin $display("FAIL idle_wr c%0d: got %b expected 0", c, bus.q_m_wr_en); fails++; end
            tests++; if (bus.q_m_addr !== 19'h05555) begin $display("FAIL idle_addr c%0d: got %h expected 05555", c, bus.q_m_addr); fails++; end
        end
        @(negedge clk);
        bus.q_m_ack = 1'b0;
        set_port(2, 1'b1, 19'h00222, 16'h0, 1'b0, 2'b11);
        #1;
        tests++; if (bus.q_m_access !== 1'b1) begin $display("FAIL idle_then_access: got %b expected 1", bus.q_m_access); fails++; end
        @(negedge clk);
        bus.q_m_ack = 1'b1;
        #1;
        tests++; if (bus.req_ack !== 4'b0100) begin $display("FAIL idle_then_ack: got %b expected 0100", bus.req_ack); fails++; end
        @(negedge clk);
        clear_all();
    endtask

    task automatic test_random();
        logic          act [N];
        logic          dropped [N];
        logic          acked [N];
        logic [AW-1:0] m_addr [N];
        logic [DW-1:0] m_data [N];
        logic          m_wr [N];
        logic [BW-1:0] m_bs [N];
        logic [N-1:0]  accv;
        logic [N-1:0]  e_ack;
        logic          busy, ack, e_acc, e_wr;
        logic [DW-1:0] din;
        int            owner, last_owner, ptr, win, e_sel;
        busy = 1'b0; owner = 0; last_owner = 0; ptr = 0;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; dropped[i] = 1'b0; acked[i] = 1'b0;
            m_addr[i] = '0; m_data[i] = '0; m_wr[i] = 1'b0; m_bs[i] = '0;
        end
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (acked[i]) begin act[i] = 1'b0; dropped[i] = 1'b0; acked[i] = 1'b0; end
                if (!act[i] && $urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1;
                    m_addr[i] = AW'($urandom); m_data[i] = DW'($urandom);
                    m_wr[i] = 1'($urandom); m_bs[i] = BW'($urandom);
                end
                if (act[i] && busy && owner == i && $urandom_range(0, 7) == 0) dropped[i] = 1'b1;
                accv[i] = act[i] && !dropped[i];
                set_port(i, accv[i], m_addr[i], m_data[i], m_wr[i], m_bs[i]);
            end
            ack = 1'($urandom);
            din = DW'($urandom);
            bus.q_m_ack = ack;
            bus.q_m_data_in = din;
            #1;
            win = pick(accv, RR ? ptr : 0);
            if (!busy) begin
                e_sel = (accv != '0) ? win : 0;
                e_acc = (accv != '0);
                e_wr  = (accv != '0) && m_wr[e_sel];
                e_ack = '0;
            end else begin
                e_sel = owner;
                e_acc = !ack;
                e_wr  = m_wr[owner];
                e_ack = ack ? 4'(1 << owner) : 4'b0000;
            end
            tests++; if (bus.req_ack !== e_ack) begin $display("FAIL rand_ack cyc%0d: got %b expected %b", cyc, bus.req_ack, e_ack); fails++; end
            tests++; if (bus.q_m_access !== e_acc) begin $display("FAIL rand_access cyc%0d: got %b expected %b", cyc, bus.q_m_access, e_acc); fails++; end
            tests++; if (bus.q_m_addr !== m_addr[e_sel]) begin $display("FAIL rand_addr cyc%0d: got %h expected %h", cyc, bus.q_m_addr, m_addr[e_sel]); fails++; end
            tests++; if (bus.q_m_data_out !== m_data[e_sel]) begin $display("FAIL rand_wdata cyc%0d: got %h expected %h", cyc, bus.q_m_data_out, m_data[e_sel]); fails++; end
            tests++; if (bus.q_m_wr_en !== e_wr) begin $display("FAIL rand_wr cyc%0d: got %b expected %b", cyc, bus.q_m_wr_en, e_wr); fails++; end
            tests++; if (bus.q_m_bytesel !== m_bs[e_sel]) begin $display("FAIL rand_bs cyc%0d: got %b expected %b", cyc, bus.q_m_bytesel, m_bs[e_sel]); fails++; end
            tests++; if (bus.req_data_in !== din) begin $display("FAIL rand_rdata cyc%0d: got %h expected %h", cyc, bus.req_data_in, din); fails++; end
            tests++; if (int'(bus.grant_idx) !== last_owner) begin $display("FAIL rand_grant cyc%0d: got %0d expected %0d", cyc, bus.grant_idx, last_owner); fails++; end
            if (!busy && accv != '0) begin
                busy = 1'b1; owner = win; last_owner = win;
            end else if (busy && ack) begin
                busy = 1'b0;
                acked[owner] = 1'b1;
                ptr = (owner + 1) % N;
            end
        end
        @(negedge clk);
        clear_all();
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single_read();
        test_two_port_priority();
        test_hold_all();
        test_drop_access();
        test_reset_mid();
        test_idle_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_mem_arbiter.md
# multi_mem_arbiter

N-port generalisation of the CPU's two-port memory arbiter: multiplexes up to NUM_PORTS bus masters onto a single downstream memory bus using the same access/ack protocol. It sits between the core's bus masters (port 0 = data, port 1 = instruction, further ports for DMA/debug) and the memory/IO fabric. It holds one outstanding transaction at a time, registers the grant for the whole transaction, and supports fixed-priority or round-robin selection.

## Interface
- NUM_PORTS, 4, number of requesting ports (2..8)
- ADDR_W, 19, word address width (bus address bits [ADDR_W:1])
- DATA_W, 16, data width; BYTESEL_W = DATA_W/8

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_addr  in  NUM_PORTS*ADDR_W  packed per-port word addresses, port i at [i*ADDR_W +: ADDR_W]
- req_data_out  in  NUM_PORTS*DATA_W  packed per-port write data
- req_access  in  NUM_PORTS  per-port access request
- req_wr_en  in  NUM_PORTS  per-port write enable
- req_bytesel  in  NUM_PORTS*BYTESEL_W  packed per-port byte selects
- req_data_in  out  DATA_W  read data, shared by all ports (= q_m_data_in)
- req_ack  out  NUM_PORTS  per-port one-hot ack
- q_m_addr  out  ADDR_W  downstream address
- q_m_data_in  in  DATA_W  downstream read data
- q_m_data_out  out  DATA_W  downstream write data
- q_m_access  out  1  downstream request
- q_m_ack  in  1  downstream ack
- q_m_wr_en  out  1  downstream write enable
- q_m_bytesel  out  BYTESEL_W  downstream byte selects
- grant_idx  out  $clog2(NUM_PORTS)  currently selected port (debug/trace)

## Operation
- States: IDLE, GRANTED. Reset: IDLE, grant register 0, rr pointer 0.
- IDLE: winner picked combinationally from req_access; q_m_* muxed from winner; q_m_access = |req_access. If any request at clock edge: latch winner, go GRANTED.
- GRANTED: q_m_* muxed from latched grant; q_m_access = ~q_m_ack; req_ack[grant] = q_m_ack. On q_m_ack: go IDLE; rr pointer <= (grant+1) mod NUM_PORTS.
- No request in IDLE: q_m_addr/data_out/bytesel from port 0, q_m_wr_en = 0, q_m_access = 0.
- q_m_ack in IDLE ignored; no req_ack ever asserted in IDLE.
- Requesters hold access and all qualifiers until their ack; dropping access mid-transaction does not abort — transaction completes, ack still pulses.
- Simultaneous requests: only the winner proceeds; losers wait, unacked.
- reset mid-transaction: immediately IDLE, all req_ack low, q_m_access follows IDLE rule.
- Outputs during reset: req_ack = 0, q_m_wr_en = 0 unless a request is present, grant_idx = 0.

## Timing
- Arbitration zero-latency: q_m_access asserts the same cycle as the first req_access.
- Earliest ack: cycle after the first request (q_m_ack must arrive while GRANTED).
- req_ack combinational from q_m_ack, same cycle; req_data_in valid in that cycle.
- After ack, one IDLE cycle before next grant: max throughput one transfer per 2 cycles.
- q_m_access low in the ack cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: search starts at rr pointer, wraps, first requester wins; pointer updated on each ack.
- Undefined: fixed priority, lowest index wins (port 0 = data beats port 1 = instruction); rr pointer logic absent, selection identical to the two-port arbiter.

## Structure
- mem_arb_pkg: port index constants (PORT_DATA=0, PORT_INSTR=1), state enum (IDLE, GRANTED).
- One sub-module: rr_priority_picker — combinational find-first-set over NUM_PORTS starting at a given index, returning index and valid; instantiated with start 0 when round-robin is disabled.

## Test plan
- Port 2 alone reads 0x1234 at addr 0x00100, memory acks after 3 cycles -> q_m_addr=0x00100, req_ack=0b0100 for exactly one cycle, req_data_in=0x1234.
- Ports 0 and 1 request together, fixed priority -> port 0 acked first, then port 1 after one IDLE cycle; q_m_wr_en/bytesel follow port 0 then port 1 values.
- Round-robin, ports 0..3 held requesting, 1-cycle ack -> ack order 0,1,2,3,0; each port acked every 8 cycles.
- Port 1 write 0xBEEF bytesel 0b10, port 1 drops access one cycle before ack -> ack still pulses on port 1, q_m_data_out=0xBEEF, q_m_bytesel=0b10 throughout.
- reset asserted while GRANTED with pending q_m_ack -> req_ack=0 that cycle; after release, fresh arbitration from pointer 0.
- q_m_ack pulsed while IDLE with no requests -> no req_ack, state stays IDLE.
